// File: rtl/chain_loader.sv
// ---------------------------------------------------------------------------
// chain_loader
//
// Serially loads a CHAIN_LEN-bit word into an external shift-register
// configuration chain. The word goes out MSB first on din. Each bit is clocked
// into the chain by one scl pulse, whose half-period is DIV clk cycles. With
// the CHAIN_READBACK_EN macro defined, the bits returning on dout are captured.
// The captured word is presented on rdata once the transfer completes.
//
// Transfer shape: SETUP (scl low, DIV cycles), then CHAIN_LEN x HIGH phases
// interleaved with CHAIN_LEN-1 x LOW phases, then HOLD (DIV cycles).
// busy is therefore high for DIV*(2*CHAIN_LEN+1) cycles.
//
// Parameters:
//   CHAIN_LEN  number of bits in the target chain (>= 2)
//   DIV        scl half-period in clk cycles (1..255)
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   asynchronous reset, active low
//   start  in   load request, only sampled while idle
//   wdata  in   word to shift into the chain (bit CHAIN_LEN-1 first)
//   busy   out  transfer in progress
//   done   out  one-cycle pulse on the cycle after the transfer ends
//   scl    out  chain shift clock, idles low
//   cs     out  active-high chain select
//   din    out  serial data to the chain
//   dout   in   serial data returned from the chain tail
//   rdata  out  chain contents shifted out during the last transfer
//
// Configuration macro: CHAIN_READBACK_EN
//   defined   -> dout capture register and rdata register are built
//   undefined -> dout is ignored and rdata is tied to zero
// ---------------------------------------------------------------------------
module chain_loader #(
    parameter int CHAIN_LEN = 264,
    parameter int DIV       = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CHAIN_LEN-1:0] wdata,
    output logic                 busy,
    output logic                 done,
    output logic                 scl,
    output logic                 cs,
    output logic                 din,
    input  logic                 dout,
    output logic [CHAIN_LEN-1:0] rdata
);

    localparam int HW = $clog2(DIV + 1);
    localparam int BW = $clog2(CHAIN_LEN + 1);

    localparam logic [HW-1:0] HALF_LAST = HW'(DIV - 1);
    localparam logic [BW-1:0] BITS_ALL  = BW'(CHAIN_LEN);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SETUP = 3'd1;
    localparam logic [2:0] HIGH  = 3'd2;
    localparam logic [2:0] LOW   = 3'd3;
    localparam logic [2:0] HOLD  = 3'd4;

    logic [2:0]           state_q, state_d;
    logic [HW-1:0]        half_q,  half_d;
    logic [BW-1:0]        bit_q,   bit_d;
    logic [CHAIN_LEN-1:0] shift_q, shift_d;
    logic                 done_q,  done_d;
    logic                 halfEnd;

    assign halfEnd = (half_q == HALF_LAST);

    // Every timed state lasts exactly DIV cycles. half_q counts the cycles spent
    // in the current state and returns to zero on each state change. bit_q
    // counts HIGH phases entered, so on HIGH exit it is the number of bits sent.
    always_comb begin
        state_d = state_q;
        half_d  = half_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d = wdata;
                    state_d = SETUP;
                    half_d  = '0;
                    bit_d   = '0;
                end
            end
            SETUP: begin
                if (halfEnd) begin
                    state_d = HIGH;
                    half_d  = '0;
                    bit_d   = bit_q + 1'b1;
                end else begin
                    half_d  = half_q + 1'b1;
                end
            end
            HIGH: begin
                if (halfEnd) begin
                    half_d = '0;
                    if (bit_q < BITS_ALL) begin
                        // The next bit appears as scl falls, so din is settled
                        // well before the following rising edge.
                        state_d = LOW;
                        shift_d = {shift_q[CHAIN_LEN-2:0], 1'b0};
                    end else begin
                        state_d = HOLD;
                    end
                end else begin
                    half_d = half_q + 1'b1;
                end
            end
            LOW: begin
                if (halfEnd) begin
                    state_d = HIGH;
                    half_d  = '0;
                    bit_d   = bit_q + 1'b1;
                end else begin
                    half_d  = half_q + 1'b1;
                end
            end
            HOLD: begin
                if (halfEnd) begin
                    state_d = IDLE;
                    half_d  = '0;
                    bit_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    half_d  = half_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                half_d  = '0;
                bit_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            half_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            half_q  <= half_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            done_q  <= done_d;
        end
    end

    // The chain-facing outputs decode directly from the state register.
    // din is forced low while idle so that stale shift data never leaks out.
    assign busy = (state_q != IDLE);
    assign cs   = (state_q != IDLE);
    assign scl  = (state_q == HIGH);
    assign din  = (state_q != IDLE) & shift_q[CHAIN_LEN-1];
    assign done = done_q;

`ifdef CHAIN_READBACK_EN
    logic [CHAIN_LEN-1:0] cap_q;
    logic [CHAIN_LEN-1:0] rdata_q;
    logic                 enterHigh;
    logic                 holdEnd;

    assign enterHigh = ((state_q == SETUP) || (state_q == LOW)) && halfEnd;
    assign holdEnd   = (state_q == HOLD) && halfEnd;

    // dout is sampled on the same clk edge that raises scl. At that edge the
    // chain has not yet shifted, so each sample is the tail bit before the
    // shift. After CHAIN_LEN samples, cap_q holds the old chain contents in
    // MSB-first order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_q   <= '0;
            rdata_q <= '0;
        end else begin
            if (enterHigh) begin
                cap_q <= {cap_q[CHAIN_LEN-2:0], dout};
            end
            if (holdEnd) begin
                rdata_q <= cap_q;
            end
        end
    end

    assign rdata = rdata_q;
`else
    logic unusedDout;

    assign unusedDout = dout;
    assign rdata      = '0;
`endif

endmodule
